lh_spi_master: RTL and testbench
================================

LH_SPI_MASTER -- requirements
Module: lh_spi_master

Interface
REQ-001 The block SHALL take parameter NUM_LH_SENSORS, default 3, the number of lighthouse sensors read per frame.
REQ-002 The block SHALL take parameter HALF_PERIOD, default 8, the CLK cycles per SCLK phase; the legal minimum is 4.
REQ-003 The block SHALL take parameter SETUP_CYCLES, default 16, the CLK cycles from SSEL falling to the first SCLK rise.
REQ-004 The block SHALL take parameter HOLD_CYCLES, default 48, the CLK cycles from the last SCLK fall to SSEL rising.
REQ-005 The block SHALL have CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have START, input, 1 bit: a one-cycle request to read one frame.
REQ-008 The block SHALL have BUSY, output, 1 bit: high from START acceptance until DONE.
REQ-009 The block SHALL have DONE, output, 1 bit: a one-cycle pulse at the end of a frame.
REQ-010 The block SHALL have SSEL, output, 1 bit: active-low slave select.
REQ-011 The block SHALL have SCLK, output, 1 bit: SPI mode-0 clock, idle low.
REQ-012 The block SHALL have MOSI, output, 1 bit: held at 1 while SSEL is low, 0 otherwise.
REQ-013 The block SHALL have MISO, input, 1 bit: serial data from the System, asynchronous to CLK.
REQ-014 The block SHALL have WORD_DATA, output, 32 bits: the received word, MSB first on the wire.
REQ-015 The block SHALL have WORD_INDEX, output, clog2(NUM_LH_SENSORS*4) bits: the word number within the frame, starting at 0.
REQ-016 The block SHALL have WORD_VALID, output, 1 bit, and WORD_READY, input, 1 bit: the output handshake.

Function
REQ-017 A frame SHALL consist of exactly NUM_LH_SENSORS*4 words of 32 bits, which is NUM_LH_SENSORS*128 SCLK periods.
REQ-018 The FSM states SHALL be IDLE, SETUP, SHIFT, STALL, TRAIL and FINISH.
REQ-019 IDLE: START -> SETUP, with SSEL driven low and BUSY high on the next cycle; START in any other state SHALL be ignored.
REQ-020 SETUP: after SETUP_CYCLES cycles -> SHIFT, with SCLK still low.
REQ-021 SHIFT: a divider counts HALF_PERIOD cycles per phase, and SCLK SHALL toggle at each terminal count.
REQ-022 MISO SHALL pass through a 2-flop synchronizer.
REQ-023 The synchronized MISO SHALL be shifted into the 32-bit shift register exactly 2 CLK cycles after each SCLK 0->1 transition.
REQ-024 The bit counter SHALL wrap at 32; after the 32nd sample the word SHALL be copied into the output register on the next SCLK fall.
REQ-025 WORD_VALID SHALL rise one CLK cycle after that copy, with WORD_INDEX set to the word count.
REQ-026 A transfer SHALL occur on any cycle with WORD_VALID and WORD_READY both high; WORD_VALID SHALL drop the next cycle unless a new word is loaded in that same cycle.
REQ-027 WORD_DATA and WORD_INDEX SHALL stay stable while WORD_VALID is high and WORD_READY is low.
REQ-028 Back-pressure: if a word completes while the output register is still valid, the FSM SHALL enter STALL with SCLK held low and the divider frozen.
REQ-029 The FSM SHALL leave STALL for SHIFT on the cycle after the pending transfer; no bit SHALL be lost or duplicated.
REQ-030 Completion of a word and a simultaneous transfer of the previous word SHALL load the new word with no stall.
REQ-031 After the SCLK fall of the last word -> TRAIL, then after HOLD_CYCLES cycles -> FINISH, which raises SSEL.
REQ-032 FINISH SHALL wait until the last word is transferred, then pulse DONE for 1 cycle, drop BUSY on the same cycle and return to IDLE.
REQ-033 With HALF_PERIOD=8 and WORD_READY tied high, SCLK SHALL be exactly 16 CLK cycles per bit with a 50% duty cycle.

Reset
REQ-034 When RST_N is low, the block SHALL asynchronously set SSEL=1, SCLK=0, MOSI=0, BUSY=0, DONE=0 and WORD_VALID=0.
REQ-035 Reset SHALL also clear WORD_DATA, WORD_INDEX, the shift register, all counters and the synchronizer, and set the FSM to IDLE.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately and emit no further word or DONE.
REQ-037 After RST_N rises, the block SHALL require a new START.

Verification
REQ-038 Scenario: slave model serves 12 words 0x00000000..0x0000000B with WORD_READY=1 -> 12 WORD_VALID pulses with indices 0..11, data matching, 384 SCLK rises, then one DONE pulse.
REQ-039 Scenario: word pattern 0xA5C3_0F81 -> WORD_DATA=0xA5C30F81, confirming MSB-first order and correct sample phase.
REQ-040 Scenario: WORD_READY held low for 200 cycles after word 2 -> SCLK stays low in STALL, word 3 is intact, and there are no extra SCLK edges.
REQ-041 Scenario: START pulsed again mid-frame -> ignored; exactly 12 words and 1 DONE.
REQ-042 Scenario: RST_N pulsed low during word 5 -> SSEL=1 and SCLK=0 in the same cycle, with no further WORD_VALID or DONE.
REQ-043 Scenario: timing check -> SSEL-low to first SCLK rise is 16 cycles and last SCLK fall to SSEL-high is 48 cycles.

Source files
------------

// File: rtl/lh_spi_master.sv
// SPI mode-0 master that reads one frame of NUM_LH_SENSORS*4 32-bit words from the
// lighthouse front end and hands each word out over a WORD_VALID/WORD_READY interface.
module lh_spi_master #(
  parameter int NUM_LH_SENSORS = 3,
  parameter int HALF_PERIOD    = 8,
  parameter int SETUP_CYCLES   = 16,
  parameter int HOLD_CYCLES    = 48
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 START,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 SSEL,
  output logic                                 SCLK,
  output logic                                 MOSI,
  input  logic                                 MISO,
  output logic [31:0]                          WORD_DATA,
  output logic [$clog2(NUM_LH_SENSORS*4)-1:0]  WORD_INDEX,
  output logic                                 WORD_VALID,
  input  logic                                 WORD_READY
);

  localparam int NUM_WORDS = NUM_LH_SENSORS * 4;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int DIV_W     = $clog2(HALF_PERIOD);
  localparam int PHASE_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, TRAIL, FINISH} state_t;

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;
  logic [IDX_W-1:0]   word_cnt;
  logic [31:0]        shift_reg;
  logic [1:0]         miso_sync;
  logic [1:0]         sample_dly;
  logic               word_full;

  logic div_tc;
  logic sclk_rise;
  logic sclk_fall;
  logic out_free;
  logic last_word;
  logic load_word;

  assign div_tc    = (div_cnt == DIV_W'(HALF_PERIOD - 1));
  assign sclk_rise = (state == SHIFT) && div_tc && !SCLK;
  assign sclk_fall = (state == SHIFT) && div_tc && SCLK;
  assign out_free  = !WORD_VALID || WORD_READY;
  assign last_word = (word_cnt == IDX_W'(NUM_WORDS - 1));
  // A finished word moves to the output register on its closing SCLK fall, or later out of STALL.
  assign load_word = (sclk_fall && word_full && out_free) || ((state == STALL) && out_free);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (START) state_next = SETUP;
      SETUP:  if (phase_cnt == PHASE_W'(SETUP_CYCLES - 2)) state_next = SHIFT;
      SHIFT: begin
        if (sclk_fall && word_full) begin
          if (!out_free)      state_next = STALL;
          else if (last_word) state_next = TRAIL;
        end
      end
      STALL:  if (out_free) state_next = last_word ? TRAIL : SHIFT;
      TRAIL:  if (phase_cnt == PHASE_W'(HOLD_CYCLES - 1)) state_next = FINISH;
      FINISH: if (!WORD_VALID) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SETUP ends one cycle early with the divider preloaded so the first rise lands on SETUP_CYCLES.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_cnt <= '0;
      div_cnt   <= '0;
      SCLK      <= 1'b0;
    end else begin
      if (state_next != state)
        phase_cnt <= '0;
      else if ((state == SETUP) || (state == TRAIL))
        phase_cnt <= phase_cnt + PHASE_W'(1);

      if ((state == SETUP) && (state_next == SHIFT))
        div_cnt <= DIV_W'(HALF_PERIOD - 1);
      else if (state == SHIFT)
        div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);

      if ((state == SHIFT) && div_tc)
        SCLK <= !SCLK;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      miso_sync  <= '0;
      sample_dly <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_full  <= 1'b0;
    end else begin
      miso_sync  <= {miso_sync[0], MISO};
      sample_dly <= {sample_dly[0], sclk_rise};
      if ((state == IDLE) && START) begin
        bit_cnt   <= '0;
        word_full <= 1'b0;
      end else begin
        if (sample_dly[1]) begin
          shift_reg <= {shift_reg[30:0], miso_sync[1]};
          bit_cnt   <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) word_full <= 1'b1;
        end
        if (load_word) word_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WORD_DATA  <= '0;
      WORD_INDEX <= '0;
      WORD_VALID <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if ((state == IDLE) && START)
        word_cnt <= '0;
      if (load_word) begin
        WORD_DATA  <= shift_reg;
        WORD_INDEX <= word_cnt;
        WORD_VALID <= 1'b1;
        word_cnt   <= word_cnt + IDX_W'(1);
      end else if (WORD_VALID && WORD_READY) begin
        WORD_VALID <= 1'b0;
      end
    end
  end

  // Frame-level outputs are registered from the next state so they change with the transition.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SSEL <= 1'b1;
      MOSI <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      SSEL <= (state_next == IDLE) || (state_next == FINISH);
      MOSI <= !((state_next == IDLE) || (state_next == FINISH));
      BUSY <= (state_next != IDLE);
      DONE <= (state == FINISH) && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_lh_spi_master.sv
// Self-checking bench for lh_spi_master: a mode-0 slave model feeds frames, and a
// scoreboard of expected words is compared against every WORD_VALID/WORD_READY transfer.
module tb_lh_spi_master;

  localparam int NUM_WORDS = 12;
  localparam int HALF      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        ssel;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [31:0] word_data;
  logic [3:0]  word_index;
  logic        word_valid;
  logic        word_ready;

  lh_spi_master dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start),
    .BUSY       (busy),
    .DONE       (done),
    .SSEL       (ssel),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .WORD_DATA  (word_data),
    .WORD_INDEX (word_index),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [35:0] exp_q[$];
  logic [35:0] sb_item;
  logic [31:0] slave_words [NUM_WORDS];
  int          slave_pos = 0;

  int cyc = 0;
  int words_seen, done_seen, rise_cnt;
  int period_err, duty_err, hold_err, busy_err, mosi_err;
  int t_ssel_fall, t_first_rise, t_last_fall, t_ssel_rise, t_last_rise;
  bit got_first, have_rise;
  logic        prev_sclk = 1'b0, prev_ssel = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_index = '0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
  endtask

  // Mode-0 slave: MSB out on SSEL fall, next bit shortly after each SCLK fall.
  function automatic logic slave_bit(input int pos);
    if (pos >= NUM_WORDS * 32) return 1'b0;
    return slave_words[pos / 32][31 - (pos % 32)];
  endfunction

  always @(negedge ssel) begin
    slave_pos = 0;
    #3 miso = slave_bit(0);
  end

  always @(negedge sclk) begin
    if (ssel === 1'b0) begin
      slave_pos++;
      #3 miso = slave_bit(slave_pos);
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (word_valid && word_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check_output("sb_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_item = exp_q.pop_front();
          check_output("word_data", word_data, sb_item[31:0]);
          check_output("word_index", 32'(word_index), 32'(sb_item[35:32]));
        end
      end
      if (prev_valid && !prev_ready && word_valid &&
          (word_data !== prev_data || word_index !== prev_index)) hold_err++;
      if (done) begin
        done_seen++;
        if (busy) busy_err++;
      end
      if (mosi === ssel) mosi_err++;
      if (prev_ssel && !ssel) begin
        t_ssel_fall = cyc;
        got_first   = 1'b0;
        have_rise   = 1'b0;
      end
      if (!prev_ssel && ssel) t_ssel_rise = cyc;
      if (!prev_sclk && sclk) begin
        rise_cnt++;
        if (!got_first) begin
          t_first_rise = cyc;
          got_first    = 1'b1;
        end
        if (have_rise && (cyc - t_last_rise != 2 * HALF)) period_err++;
        t_last_rise = cyc;
        have_rise   = 1'b1;
      end
      if (prev_sclk && !sclk) begin
        t_last_fall = cyc;
        if (have_rise && (cyc - t_last_rise != HALF)) duty_err++;
      end
    end
    prev_sclk  = sclk;
    prev_ssel  = ssel;
    prev_valid = word_valid;
    prev_ready = word_ready;
    prev_data  = word_data;
    prev_index = word_index;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // kind 0: counting words, kind 1: fixed bit-order pattern first, otherwise random.
  task automatic apply_stimulus(input int kind);
    logic [31:0] w;
    words_seen = 0; done_seen = 0; rise_cnt = 0;
    period_err = 0; duty_err = 0; hold_err = 0; busy_err = 0; mosi_err = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      case (kind)
        0:       w = 32'(i);
        1:       w = (i == 0) ? 32'hA5C3_0F81 : $urandom();
        default: w = $urandom();
      endcase
      slave_words[i] = w;
      exp_q.push_back({4'(i), w});
    end
    pulse_start();
  endtask

  task automatic wait_done(input string tag, input bit timing);
    for (int i = 0; i < 20000 && done_seen == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_output({tag, "_done"},    32'(done_seen), 32'd1);
    check_output({tag, "_words"},   32'(words_seen), 32'(NUM_WORDS));
    check_output({tag, "_rises"},   32'(rise_cnt), 32'(NUM_WORDS * 32));
    check_output({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    check_output({tag, "_busy"},    32'(busy), 32'd0);
    check_output({tag, "_ssel"},    32'(ssel), 32'd1);
    check_output({tag, "_hold"},    32'(hold_err), 32'd0);
    check_output({tag, "_busydone"}, 32'(busy_err), 32'd0);
    check_output({tag, "_mosi"},    32'(mosi_err), 32'd0);
    if (timing) begin
      check_output({tag, "_setup_cyc"}, 32'(t_first_rise - t_ssel_fall), 32'd16);
      check_output({tag, "_hold_cyc"},  32'(t_ssel_rise - t_last_fall), 32'd48);
      check_output({tag, "_period"},    32'(period_err), 32'd0);
      check_output({tag, "_duty"},      32'(duty_err), 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    int r0;
    int stall_hi;
    int w0;
    rst_n = 1'b0; start = 1'b0; word_ready = 1'b1; miso = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_ssel",  32'(ssel), 32'd1);
    check_output("rst_sclk",  32'(sclk), 32'd0);
    check_output("rst_mosi",  32'(mosi), 32'd0);
    check_output("rst_busy",  32'(busy), 32'd0);
    check_output("rst_done",  32'(done), 32'd0);
    check_output("rst_valid", 32'(word_valid), 32'd0);
    check_output("rst_data",  word_data, 32'd0);
    check_output("rst_index", 32'(word_index), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("idle_ssel", 32'(ssel), 32'd1);

    $display("[TB] frame with counting words and timing checks");
    apply_stimulus(0);
    wait_done("count", 1'b1);

    $display("[TB] frame with bit-order pattern");
    apply_stimulus(1);
    wait_done("pattern", 1'b0);

    $display("[TB] frame with back-pressure");
    apply_stimulus(2);
    for (int i = 0; i < 20000 && words_seen < 2; i++) @(negedge clk);
    check_output("bp_reach_w1", 32'(words_seen), 32'd2);
    @(posedge clk);
    #1 word_ready = 1'b0;
    for (int i = 0; i < 20000 && !(word_valid && word_index == 4'd2); i++) @(negedge clk);
    check_output("bp_w2_valid", 32'(word_valid), 32'd1);
    repeat (530) @(negedge clk);
    r0 = rise_cnt;
    stall_hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (sclk) stall_hi++;
    end
    check_output("stall_rises",  32'(rise_cnt - r0), 32'd0);
    check_output("stall_sclk",   32'(stall_hi), 32'd0);
    check_output("stall_index",  32'(word_index), 32'd2);
    check_output("stall_busy",   32'(busy), 32'd1);
    @(posedge clk);
    #1 word_ready = 1'b1;
    wait_done("stall", 1'b0);

    $display("[TB] frame with a second START mid-frame");
    apply_stimulus(2);
    repeat (1500) @(negedge clk);
    pulse_start();
    wait_done("restart", 1'b0);

    $display("[TB] frame aborted by reset");
    apply_stimulus(2);
    for (int i = 0; i < 20000 && words_seen < 5; i++) @(negedge clk);
    check_output("abort_reach_w4", 32'(words_seen), 32'd5);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_ssel",  32'(ssel), 32'd1);
    check_output("abort_sclk",  32'(sclk), 32'd0);
    check_output("abort_valid", 32'(word_valid), 32'd0);
    check_output("abort_busy",  32'(busy), 32'd0);
    exp_q.delete();
    w0 = words_seen;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    check_output("abort_no_word", 32'(words_seen), 32'(w0));
    check_output("abort_no_done", 32'(done_seen), 32'd0);
    check_output("abort_idle",    32'(busy), 32'd0);
    check_output("abort_ssel_hi", 32'(ssel), 32'd1);

    $display("[TB] frame after reset recovery");
    apply_stimulus(0);
    wait_done("recover", 1'b0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
